// File: rtl/interrupt_sequencer_if.sv
// Pin bundle between the 6502 core (master) and the cycle/interrupt sequencer (slave).
// The master drives the pins and decoder hints. The slave returns the microcode step and the sequencing controls.
interface interrupt_sequencer_if;
  logic       rdy;
  logic       nmi_n;
  logic       irq_n;
  logic       i_flag;
  logic       insn_done;
  logic       ir_is_brk;
  logic [2:0] tstate;
  logic       sync;
  logic       inject_brk;
  logic       write_inhibit;
  logic       b_flag;
  logic [1:0] vector_sel;

  modport master (
    output rdy, nmi_n, irq_n, i_flag, insn_done, ir_is_brk,
    input  tstate, sync, inject_brk, write_inhibit, b_flag, vector_sel
  );

  modport slave (
    input  rdy, nmi_n, irq_n, i_flag, insn_done, ir_is_brk,
    output tstate, sync, inject_brk, write_inhibit, b_flag, vector_sel
  );
endinterface

// File: rtl/interrupt_sequencer.sv
// 6502 cycle/interrupt sequencer. It owns the T-state counter, the reset sequence,
// NMI edge capture, IRQ/NMI injection at instruction boundaries, and vector selection with NMI hijack.
module interrupt_sequencer #(
  parameter int unsigned RST_CYCLES = 7
) (
  input logic                 clk,
  input logic                 rst_n,
  interrupt_sequencer_if.slave bus
);

  typedef enum logic [1:0] {ST_RST, ST_RUN, ST_INT} state_e;

  localparam logic [1:0] VEC_IRQ  = 2'b00;
  localparam logic [1:0] VEC_NMI  = 2'b01;
  localparam logic [1:0] VEC_RST  = 2'b10;
  localparam logic [2:0] RST_LAST = 3'(RST_CYCLES - 1);
  localparam logic [2:0] INT_LAST = 3'd6;
  localparam logic [2:0] HIJACK_T = 3'd4;

  state_e     state_q, state_d;
  logic [2:0] tstate_q, tstate_d;
  logic       sync_q, sync_d;
  logic       inj_q, inj_d;
  logic       wi_q, wi_d;
  logic       bf_q, bf_d;
  logic [1:0] vec_q, vec_d;
  logic       nmi_pend_q, nmi_pend_d;
  logic       nmi_prev_q, nmi_prev_d;

  logic [2:0] tstate_inc;
  logic       nmi_edge;
  logic       nmi_commit;
  logic       hijack_ok;

  always_comb begin
    state_d    = state_q;
    tstate_d   = tstate_q;
    vec_d      = vec_q;
    nmi_commit = 1'b0;

    // The counter saturates at 7. A runaway instruction holds there until the decoder ends it.
    tstate_inc = (tstate_q == 3'd7) ? 3'd7 : tstate_q + 3'd1;
    nmi_edge   = nmi_prev_q & ~bus.nmi_n;
    hijack_ok  = (state_q == ST_RUN && bus.ir_is_brk && !bus.insn_done) ||
                 (state_q == ST_INT && vec_q == VEC_IRQ);

    if (bus.rdy) begin
      unique case (state_q)
        ST_RST: begin
          if (tstate_q == RST_LAST) begin
            state_d  = ST_RUN;
            tstate_d = 3'd0;
            vec_d    = VEC_IRQ;
          end else begin
            tstate_d = tstate_inc;
          end
        end
        ST_RUN: begin
          if (bus.insn_done) begin
            tstate_d = 3'd0;
            vec_d    = VEC_IRQ;
            if (nmi_pend_q) begin
              state_d    = ST_INT;
              vec_d      = VEC_NMI;
              nmi_commit = 1'b1;
            end else if (!bus.irq_n && !bus.i_flag) begin
              state_d = ST_INT;
            end
          end else begin
            tstate_d = tstate_inc;
          end
        end
        ST_INT: begin
          if (tstate_q == INT_LAST) begin
            state_d  = ST_RUN;
            tstate_d = 3'd0;
            vec_d    = VEC_IRQ;
          end else begin
            tstate_d = tstate_inc;
          end
        end
        default: begin
          state_d  = ST_RST;
          tstate_d = 3'd0;
          vec_d    = VEC_RST;
        end
      endcase

      // A late NMI redirects a BRK or IRQ stack sequence before the vector fetch at T5.
      if (hijack_ok && tstate_q == HIJACK_T && nmi_pend_q) begin
        vec_d      = VEC_NMI;
        nmi_commit = 1'b1;
      end
    end

    nmi_prev_d = bus.nmi_n;
    nmi_pend_d = nmi_edge | (nmi_pend_q & ~nmi_commit);

    if (bus.rdy) begin
      sync_d = (state_d == ST_RUN) && (tstate_d == 3'd0);
      inj_d  = (state_d != ST_RUN);
      wi_d   = (state_d == ST_RST);
      bf_d   = (state_d == ST_RUN) && bus.ir_is_brk && (tstate_d != 3'd0);
    end else begin
      sync_d = sync_q;
      inj_d  = inj_q;
      wi_d   = wi_q;
      bf_d   = bf_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RST;
      tstate_q   <= 3'd0;
      sync_q     <= 1'b0;
      inj_q      <= 1'b1;
      wi_q       <= 1'b1;
      bf_q       <= 1'b0;
      vec_q      <= VEC_RST;
      nmi_pend_q <= 1'b0;
      nmi_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      tstate_q   <= tstate_d;
      sync_q     <= sync_d;
      inj_q      <= inj_d;
      wi_q       <= wi_d;
      bf_q       <= bf_d;
      vec_q      <= vec_d;
      nmi_pend_q <= nmi_pend_d;
      nmi_prev_q <= nmi_prev_d;
    end
  end

  assign bus.tstate        = tstate_q;
  assign bus.sync          = sync_q;
  assign bus.inject_brk    = inj_q;
  assign bus.write_inhibit = wi_q;
  assign bus.b_flag        = bf_q;
  assign bus.vector_sel    = vec_q;

endmodule
